audio_gain_meter: RTL



---
 rtl/audio_gain_meter.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/audio_gain_meter.sv
// Multi-channel power-of-two gain stage with signed saturation, clip flag and a
// thermometer peak meter with peak-hold and timed one-bar-per-step decay.
module audio_gain_meter #(
    parameter int DATA_W       = 32,
    parameter int NUM_CH       = 2,
    parameter int GAIN_W       = 3,
    parameter int NUM_BARS     = 10,
    parameter int HOLD_CYCLES  = 12_500_000,
    parameter int DECAY_CYCLES = 2_500_000
) (
    input  logic                     CLOCK_50,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [GAIN_W-1:0]        gain,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic                     clip,
    output logic [NUM_BARS-1:0]      meter,
    output logic [1:0]               peak_state
);

    localparam int MAX_SH  = (1 << GAIN_W) - 1;
    localparam int WIDE_W  = DATA_W + MAX_SH;
    localparam int BARS_W  = $clog2(NUM_BARS + 1);
    localparam int CNT_MAX = (HOLD_CYCLES > DECAY_CYCLES) ? HOLD_CYCLES : DECAY_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [DATA_W-1:0] POS_MAX    = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] NEG_MIN    = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [CNT_W-1:0]  HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  DECAY_LOAD = CNT_W'(DECAY_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        DECAY = 2'd2
    } peak_state_t;

    peak_state_t             state, state_n;
    logic [BARS_W-1:0]       held, held_n;
    logic [CNT_W-1:0]        cnt, cnt_n;

    logic                    accept;
    logic [NUM_CH*DATA_W-1:0] proc_data;
    logic                    proc_clip;
    logic [DATA_W-1:0]       peak_mag;
    logic [DATA_W-1:0]       chan_x, chan_y, chan_mag;
    logic [WIDE_W-1:0]       chan_wide;
    logic [MAX_SH:0]         chan_upper;
    logic [BARS_W-1:0]       frame_bars;
    int                      msb_plus1;

    // Valid/ready: a frame moves when valid & ready are both high on a rising edge;
    // the single output register frees itself in the same cycle it is drained.
    assign in_ready = ~out_valid | out_ready;
    assign accept   = in_valid & in_ready;

    always_comb begin
        proc_data  = '0;
        proc_clip  = 1'b0;
        peak_mag   = '0;
        chan_x     = '0;
        chan_y     = '0;
        chan_mag   = '0;
        chan_wide  = '0;
        chan_upper = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            chan_x     = in_data[ch*DATA_W +: DATA_W];
            chan_wide  = {{MAX_SH{chan_x[DATA_W-1]}}, chan_x} << gain;
            // The exact product fits only if every bit above the sign position agrees.
            chan_upper = chan_wide[WIDE_W-1:DATA_W-1];
            if (!enable) begin
                chan_y = chan_x;
            end else if (!(&chan_upper) && (|chan_upper)) begin
                chan_y    = chan_wide[WIDE_W-1] ? NEG_MIN : POS_MAX;
                proc_clip = 1'b1;
            end else begin
                chan_y = chan_wide[DATA_W-1:0];
            end
            if (!chan_y[DATA_W-1]) begin
                chan_mag = chan_y;
            end else if (chan_y == NEG_MIN) begin
                chan_mag = POS_MAX;
            end else begin
                chan_mag = ~chan_y + 1'b1;
            end
            if (chan_mag > peak_mag) begin
                peak_mag = chan_mag;
            end
            proc_data[ch*DATA_W +: DATA_W] = chan_y;
        end
    end

    always_comb begin
        msb_plus1 = 0;
        for (int i = 0; i < DATA_W; i++) begin
            if (peak_mag[i]) begin
                msb_plus1 = i + 1;
            end
        end
        frame_bars = BARS_W'((msb_plus1 * NUM_BARS) / (DATA_W - 1));
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            clip      <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= proc_data;
            clip      <= proc_clip;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state <= IDLE;
            held  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            held  <= held_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        held_n  = held;
        cnt_n   = cnt;
        if (accept && (frame_bars != '0) && (frame_bars >= held)) begin
            state_n = HOLD;
            held_n  = frame_bars;
            cnt_n   = HOLD_LOAD;
        end else begin
            case (state)
                IDLE: state_n = IDLE;
                HOLD: begin
                    if (cnt == '0) begin
                        cnt_n   = DECAY_LOAD;
                        state_n = DECAY;
                    end else begin
                        cnt_n = cnt - 1'b1;
                    end
                end
                DECAY: begin
                    if (cnt == '0) begin
                        held_n = held - 1'b1;
                        if (held == BARS_W'(1)) begin
                            state_n = IDLE;
                        end else begin
                            cnt_n = DECAY_LOAD;
                        end
                    end else begin
                        cnt_n = cnt - 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_comb begin
        meter = '0;
        for (int i = 0; i < NUM_BARS; i++) begin
            if (BARS_W'(i) < held) begin
                meter[i] = 1'b1;
            end
        end
        peak_state = state;
    end

endmodule
